// File: rtl/filters_pkg.sv
// Shared constants and helpers for the Filters accumulate stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default widths, a constant-foldable clog2, default saturation limits.
package filters_pkg;

   localparam int DEF_PROD_WIDTH = 32;
   localparam int DEF_ACC_WIDTH  = 40;
   localparam int DEF_OUT_WIDTH  = 16;
   localparam int DEF_SHIFT      = 15;
   localparam int DEF_NUM_TAPS   = 16;

   // Saturation limits for the default output width.
   localparam logic signed [DEF_OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [DEF_OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

   // Number of bits needed to count 0..n-1.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/filters_round_sat.sv
// Round half toward +inf, arithmetic shift right by SHIFT, saturate to OUT_WIDTH.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: sum (accumulated value) -> data (saturated sample), sat (clipping occurred).
module filters_round_sat #(
   parameter int ACC_WIDTH = filters_pkg::DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = filters_pkg::DEF_OUT_WIDTH,
   parameter int SHIFT     = filters_pkg::DEF_SHIFT
) (
   input  logic [ACC_WIDTH-1:0] sum,
   output logic [OUT_WIDTH-1:0] data,
   output logic                 sat
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int EW = ACC_WIDTH + 1;

   // Half an LSB of the shifted result; (1<<SHIFT)>>1 is 0 when SHIFT==0.
   localparam logic signed [EW-1:0] RND    = (EW'(1) << SHIFT) >> 1;
   localparam logic signed [EW-1:0] SAT_HI = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_LO = ~SAT_HI;

   logic signed [EW-1:0] ext;
   logic signed [EW-1:0] shr;

   always_comb begin
      ext  = {sum[ACC_WIDTH-1], sum} + RND;
      shr  = ext >>> SHIFT;
      data = shr[OUT_WIDTH-1:0];
      sat  = 1'b0;
      if (shr > SAT_HI) begin
         data = SAT_HI[OUT_WIDTH-1:0];
         sat  = 1'b1;
      end else if (shr < SAT_LO) begin
         data = SAT_LO[OUT_WIDTH-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/filters_mac_acc.sv
// Accumulates NUM_TAPS signed tap products into one rounded, saturated sample.
// Latency: out_tvalid one cycle after the final product of a sample is accepted.
// Backpressure: prod_tready = !out_tvalid | out_tready; a held output stalls products.
// Ports: prod_* product stream in, out_* sample stream out,
//        clear_sticky clears sat_sticky / len_err_sticky (a same-cycle set wins).
module filters_mac_acc
   import filters_pkg::*;
#(
   parameter int PROD_WIDTH = DEF_PROD_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int SHIFT      = DEF_SHIFT,
   parameter int NUM_TAPS   = DEF_NUM_TAPS
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [PROD_WIDTH-1:0] prod_tdata,
   input  logic                  prod_tvalid,
   input  logic                  prod_tlast,
   output logic                  prod_tready,
   output logic [OUT_WIDTH-1:0]  out_tdata,
   output logic                  out_tvalid,
   input  logic                  out_tready,
   input  logic                  clear_sticky,
   output logic                  sat_sticky,
   output logic                  len_err_sticky
);

   // ACC_WIDTH >= PROD_WIDTH + clog2(NUM_TAPS) keeps the accumulator from overflowing.
   localparam int              CNT_W    = clog2(NUM_TAPS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TAPS - 1);

   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     cnt;

   logic                 accept;
   logic                 at_last;
   logic                 final_prod;
   logic [ACC_WIDTH-1:0] p_ext;
   logic [ACC_WIDTH-1:0] sum;
   logic [OUT_WIDTH-1:0] rs_data;
   logic                 rs_sat;
   logic                 sat_set;
   logic                 len_set;

   assign prod_tready = !out_tvalid | out_tready;
   assign accept      = prod_tvalid & prod_tready;
   assign at_last     = (cnt == LAST_CNT);
   // A sample closes on tlast or on the tap count, whichever comes first.
   assign final_prod  = accept & (at_last | prod_tlast);

   assign p_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
   // cnt==0 restarts the sum, so stale acc contents never need clearing.
   assign sum   = (cnt == '0) ? p_ext : acc + p_ext;

   // Short sample (early tlast) or long sample (count reached without tlast).
   assign len_set = accept & (prod_tlast ^ at_last);
   assign sat_set = final_prod & rs_sat;

   filters_round_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_round_sat (
      .sum  (sum),
      .data (rs_data),
      .sat  (rs_sat)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= sum;
         cnt <= final_prod ? '0 : cnt + 1'b1;
      end
   end

   // A final product can only be accepted when the register is free or draining,
   // so loading takes priority over the clear.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_tvalid <= 1'b0;
         out_tdata  <= '0;
      end else if (final_prod) begin
         out_tvalid <= 1'b1;
         out_tdata  <= rs_data;
      end else if (out_tready) begin
         out_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         sat_sticky     <= 1'b0;
         len_err_sticky <= 1'b0;
      end else begin
         if (sat_set)
            sat_sticky <= 1'b1;
         else if (clear_sticky)
            sat_sticky <= 1'b0;
         if (len_set)
            len_err_sticky <= 1'b1;
         else if (clear_sticky)
            len_err_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_filters_mac_acc.sv
// Self-checking bench for filters_mac_acc with NUM_TAPS=4, SHIFT=15.
// Expected samples are queued when products are driven and popped when delivered.
module tb_filters_mac_acc;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [31:0] prod_tdata = '0;
   logic        prod_tvalid = 1'b0;
   logic        prod_tlast = 1'b0;
   logic        prod_tready;
   logic [15:0] out_tdata;
   logic        out_tvalid;
   logic        out_tready = 1'b1;
   logic        clear_sticky = 1'b0;
   logic        sat_sticky;
   logic        len_err_sticky;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stalls = 0;
   logic [15:0] sb[$];
   int          vld_cyc[$];
   logic [15:0] mon_exp;

   filters_mac_acc #(
      .NUM_TAPS (4)
   ) dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .prod_tdata     (prod_tdata),
      .prod_tvalid    (prod_tvalid),
      .prod_tlast     (prod_tlast),
      .prod_tready    (prod_tready),
      .out_tdata      (out_tdata),
      .out_tvalid     (out_tvalid),
      .out_tready     (out_tready),
      .clear_sticky   (clear_sticky),
      .sat_sticky     (sat_sticky),
      .len_err_sticky (len_err_sticky)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) cyc <= cyc + 1;

   // Output monitor: a transfer is visible at the negedge before the edge that takes it.
   always @(negedge ap_clk) begin
      if (ap_rst_n && out_tvalid) vld_cyc.push_back(cyc);
      if (ap_rst_n && prod_tvalid && !prod_tready) stalls = stalls + 1;
      if (ap_rst_n && out_tvalid && out_tready) begin
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL out_unexpected got %0d required none", $signed(out_tdata));
         end else begin
            mon_exp = sb.pop_front();
            if (out_tdata !== mon_exp) begin
               errors = errors + 1;
               $display("FAIL out_tdata got %0d required %0d", $signed(out_tdata), $signed(mon_exp));
            end
         end
      end
   end

   // Round half up, shift by 15, clamp to 16 bits.
   function automatic logic [15:0] model(input longint s);
      longint r;
      r = (s + 64'sd16384) >>> 15;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   // Drive one product and wait until it is taken; returns at posedge+1.
   task automatic drive_prod(input longint v, input logic last);
      int n;
      n = 0;
      prod_tdata  = v[31:0];
      prod_tlast  = last;
      prod_tvalid = 1'b1;
      @(negedge ap_clk);
      while (!prod_tready && n < 200) begin
         @(negedge ap_clk);
         n = n + 1;
      end
      if (!prod_tready) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL send_timeout prod_tready got 0 required 1");
      end
      @(posedge ap_clk);
      #1;
      prod_tvalid = 1'b0;
      prod_tlast  = 1'b0;
   endtask

   // n products of value v forming one sample; tlast on the final one if requested.
   task automatic send_const(input int n, input longint v, input logic use_last);
      sb.push_back(model(n * v));
      for (int i = 0; i < n; i++)
         drive_prod(v, use_last && (i == n - 1));
   endtask

   task automatic pulse_clear();
      clear_sticky = 1'b1;
      @(posedge ap_clk);
      #1;
      clear_sticky = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks = checks + 4;
      if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_out_tvalid got %b required 0", out_tvalid); end
      if (out_tdata !== 16'd0) begin errors++; $display("FAIL rst_out_tdata got %0d required 0", out_tdata); end
      if (sat_sticky !== 1'b0) begin errors++; $display("FAIL rst_sat got %b required 0", sat_sticky); end
      if (len_err_sticky !== 1'b0) begin errors++; $display("FAIL rst_len got %b required 0", len_err_sticky); end
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic test_basic();
      sb.push_back(model(4 * 32768));
      for (int i = 0; i < 3; i++) drive_prod(32768, 1'b0);
      checks = checks + 1;
      if (out_tvalid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b required 0", out_tvalid); end
      drive_prod(32768, 1'b1);
      checks = checks + 2;
      if (out_tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b required 1", out_tvalid); end
      if (out_tdata !== 16'd4) begin errors++; $display("FAIL basic_data got %0d required 4", $signed(out_tdata)); end
      @(negedge ap_clk);
      checks = checks + 2;
      if (sat_sticky !== 1'b0) begin errors++; $display("FAIL basic_sat got %b required 0", sat_sticky); end
      if (len_err_sticky !== 1'b0) begin errors++; $display("FAIL basic_len got %b required 0", len_err_sticky); end
      @(posedge ap_clk);
      #1;
   endtask

   task automatic test_saturation();
      send_const(4, 64'sd1 << 30, 1'b1);
      checks = checks + 1;
      if (sat_sticky !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b required 1", sat_sticky); end
      send_const(4, -(64'sd1 << 30), 1'b1);
      @(posedge ap_clk);
      #1;
      pulse_clear();
      checks = checks + 1;
      if (sat_sticky !== 1'b0) begin errors++; $display("FAIL sat_clear got %b required 0", sat_sticky); end
      // Clear asserted in the same cycle as a saturating sample: the set must win.
      sb.push_back(model(4 * (64'sd1 << 30)));
      for (int i = 0; i < 3; i++) drive_prod(64'sd1 << 30, 1'b0);
      clear_sticky = 1'b1;
      drive_prod(64'sd1 << 30, 1'b1);
      clear_sticky = 1'b0;
      checks = checks + 1;
      if (sat_sticky !== 1'b1) begin errors++; $display("FAIL sat_set_wins got %b required 1", sat_sticky); end
      @(posedge ap_clk);
      #1;
      pulse_clear();
   endtask

   task automatic test_rounding();
      longint vals[3];
      vals[0] = -16384;
      vals[1] = -16385;
      vals[2] = 16384;
      for (int k = 0; k < 3; k++) begin
         pulse_clear();
         send_const(1, vals[k], 1'b1);
         checks = checks + 1;
         if (len_err_sticky !== 1'b1) begin errors++; $display("FAIL round_len_err[%0d] got %b required 1", k, len_err_sticky); end
         @(posedge ap_clk);
         #1;
      end
      // Long sample: four products without tlast still close a sample.
      pulse_clear();
      send_const(4, 32768, 1'b0);
      checks = checks + 1;
      if (len_err_sticky !== 1'b1) begin errors++; $display("FAIL long_len_err got %b required 1", len_err_sticky); end
      @(posedge ap_clk);
      #1;
      pulse_clear();
   endtask

   task automatic test_backpressure();
      out_tready = 1'b0;
      fork
         begin
            send_const(4, 32768, 1'b1);
            send_const(4, 98304, 1'b1);
         end
         begin
            repeat (6) @(negedge ap_clk);
            for (int i = 0; i < 3; i++) begin
               checks = checks + 3;
               if (out_tvalid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b required 1", out_tvalid); end
               if (out_tdata !== 16'd4) begin errors++; $display("FAIL bp_hold_data got %0d required 4", $signed(out_tdata)); end
               if (prod_tready !== 1'b0) begin errors++; $display("FAIL bp_prod_tready got %b required 0", prod_tready); end
               @(negedge ap_clk);
            end
            @(posedge ap_clk);
            #1;
            out_tready = 1'b1;
         end
      join
      repeat (3) @(negedge ap_clk);
      checks = checks + 2;
      if (sb.size() != 0) begin errors++; $display("FAIL bp_drain got %0d pending required 0", sb.size()); end
      if (out_tvalid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b required 0", out_tvalid); end
      @(posedge ap_clk);
      #1;
   endtask

   task automatic test_back_to_back();
      out_tready = 1'b1;
      vld_cyc.delete();
      stalls = 0;
      send_const(4, 32768, 1'b1);
      send_const(4, 65536, 1'b1);
      send_const(4, -32768, 1'b1);
      repeat (3) @(negedge ap_clk);
      checks = checks + 2;
      if (stalls != 0) begin errors++; $display("FAIL b2b_stalls got %0d required 0", stalls); end
      if (vld_cyc.size() != 3) begin
         errors++;
         $display("FAIL b2b_valid_count got %0d required 3", vld_cyc.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks = checks + 1;
            if (vld_cyc[i] - vld_cyc[i-1] != 4) begin
               errors++;
               $display("FAIL b2b_spacing got %0d required 4", vld_cyc[i] - vld_cyc[i-1]);
            end
         end
      end
      @(posedge ap_clk);
      #1;
   endtask

   task automatic test_reset_mid();
      // Leave a flag set so the reset is seen to clear it too.
      send_const(1, 5, 1'b1);
      @(posedge ap_clk);
      #1;
      drive_prod(1000000, 1'b0);
      drive_prod(1000000, 1'b0);
      ap_rst_n = 1'b0;
      #1;
      checks = checks + 2;
      if (out_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b required 0", out_tvalid); end
      if (len_err_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_len got %b required 0", len_err_sticky); end
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      send_const(4, 32768, 1'b1);
      checks = checks + 3;
      if (out_tdata !== 16'd4) begin errors++; $display("FAIL mid_rst_data got %0d required 4", $signed(out_tdata)); end
      if (sat_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_sat got %b required 0", sat_sticky); end
      if (len_err_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_len_after got %b required 0", len_err_sticky); end
      repeat (2) @(negedge ap_clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      checks = checks + 1;
      if (sb.size() != 0) begin errors++; $display("FAIL final_drain got %0d pending required 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/filters_mac_acc.md
Name: filters_mac_acc

Overview:
- Downstream accumulate/round/saturate stage for the Filters datapath.
- Consumes the signed 32-bit tap products from the 17x15 multiplier, one product per cycle, and accumulates NUM_TAPS products into one filter output.
- Rounds, scales and saturates each sum to a 16-bit sample, then presents it on a valid/ready output register.

Parameters:
- PROD_WIDTH, 32, signed product width (multiplier dout).
- ACC_WIDTH, 40, accumulator width. Must satisfy ACC_WIDTH >= PROD_WIDTH + clog2(NUM_TAPS).
- OUT_WIDTH, 16, signed output sample width.
- SHIFT, 15, arithmetic right shift applied after rounding (coefficient Q-format). Range 0..ACC_WIDTH-OUT_WIDTH.
- NUM_TAPS, 16, products per output sample. Range 2..256.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- prod_tdata  in  PROD_WIDTH  signed tap product.
- prod_tvalid  in  1  product valid.
- prod_tlast  in  1  marks the last product of a sample.
- prod_tready  out  1  stage accepts a product this cycle.
- out_tdata  out  OUT_WIDTH  signed filtered sample.
- out_tvalid  out  1  sample valid.
- out_tready  in  1  downstream accepts the sample.
- clear_sticky  in  1  synchronous clear of the sticky flags.
- sat_sticky  out  1  set when any output sample was saturated.
- len_err_sticky  out  1  set on a tlast/tap-count mismatch.

Behaviour:
- Reset (ap_rst_n low, asynchronous): accumulator=0, tap counter=0, out_tvalid=0, out_tdata=0, both sticky flags=0.
  - Any partially accumulated sample is discarded.
  - The first product accepted after reset starts a new sample.
- Handshake: prod_tready = !out_tvalid | out_tready, combinational.
  - A product is accepted when prod_tvalid & prod_tready.
  - Producers must hold data stable while valid and not ready.
- Accept, non-final product:
  - acc <= (cnt==0 ? sext(p) : acc + sext(p)).
  - cnt <= cnt+1.
- Final product: the accepted product where cnt==NUM_TAPS-1 OR prod_tlast=1.
  - sum = (cnt==0 ? sext(p) : acc + sext(p)).
  - r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. round half toward +inf.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Result is registered into out_tdata; out_tvalid=1 on the next cycle; cnt <= 0.
- Latency: 1 cycle from acceptance of the final product to out_tvalid.
- Throughput: 1 product per cycle with out_tready held high. There are no bubbles between samples.
- Output register:
  - out_tvalid clears on out_tvalid & out_tready unless a new final product is accepted in the same cycle. In that case it reloads and stays 1.
  - out_tdata is stable while out_tvalid & !out_tready.
- Saturation: sat_sticky <= 1 in the cycle the clipped value is registered.
- Length check: len_err_sticky <= 1 when either
  - prod_tlast=1 with cnt != NUM_TAPS-1 (short sample, still finalized), or
  - cnt==NUM_TAPS-1 with prod_tlast=0 (long sample, finalized; the following products begin a new sample).
- clear_sticky: clears both flags. A set event in the same cycle wins, so the flag stays 1.
- Accumulator arithmetic: two's complement throughout; overflow is impossible under the width constraint.

Decomposition:
- Package filters_pkg holds:
  - default width constants (PROD_WIDTH, ACC_WIDTH, OUT_WIDTH, SHIFT);
  - a clog2 function;
  - the saturation min/max constants.
- One combinational sub-module, filters_round_sat, performs round + shift + saturate and outputs data and a sat flag. It is instantiated once; the accumulator, counter and output register stay in the top module.

Test Plan (NUM_TAPS=4, SHIFT=15 unless stated):
- Four products of 32768, tlast on the 4th -> sum 131072, +16384, >>15 -> out_tdata=4 exactly 1 cycle later; sat_sticky=0, len_err_sticky=0.
- Four products of 2^30 -> 2^32 >>15 = 131072 -> out_tdata=32767, sat_sticky=1. Four products of -2^30 -> out_tdata=-32768.
- Rounding edge, tlast on the 1st product with NUM_TAPS=1 legalized to 2 by supplying tlast early:
  - -16384 -> out_tdata=0;
  - -16385 -> out_tdata=-1;
  - 16384 -> out_tdata=1;
  - len_err_sticky=1 in each case.
- Backpressure: out_tready=0 while 8 products (two samples) stream -> first sample held stable and prod_tready=0 once out_tvalid=1. Release out_tready -> both samples delivered in order with no loss.
- Back-to-back streaming of 3 samples with out_tready=1 -> out_tvalid high on 3 distinct cycles spaced 4 cycles apart; prod_tready constantly 1.
- Assert ap_rst_n low after 2 of 4 products, then release and send 4 products of 32768 -> out_tdata=4 (no residue), flags 0. clear_sticky pulse after a saturation event -> sat_sticky=0 on the next cycle.
